if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch front end and the reading side of the instruction ROM. It owns the PC, drives the ROM word address, and captures the combinational ROM data together with its PC into a small skid queue. It hands {pc, instr} to decode over a valid/ready handshake and accepts redirects (branch, jump, trap) from later stages.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
IM_AW, 7, ROM word-address width; im_addr carries pc[IM_AW+1:2]
QDEPTH, 2, queue entries; legal values 2 or 4

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
im_addr  out  IM_AW  ROM word address; equals pc[IM_AW+1:2] combinationally
im_dout  in  32  ROM data, valid in the same cycle as im_addr
redirect_valid  in  1  replace PC with redirect_pc and flush
redirect_pc  in  32  redirect target
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_pc  out  32  head PC
out_instr  out  32  head instruction
out_misalign  out  1  head is a misaligned-target marker
fetch_cnt  out  32  count of enqueued entries; wraps at 2^32

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC, queue count=0, head storage cleared.
  - Outputs: out_valid=0, out_pc=0, out_instr=0, out_misalign=0, fetch_cnt=0.
  - State=BOOT. rst overrides everything, including mid-redirect and a full queue.
- States:
  - BOOT: no enqueue; goes to RUN next cycle.
  - RUN: normal fetch.
  - HALT: no fetch; left only by redirect_valid.
- deq = out_valid & out_ready.
- enq_ok = (count<QDEPTH) | deq. Enqueue and dequeue in the same cycle are allowed at full.
- RUN, no redirect, enq_ok: push {pc, im_dout, 0}, pc<=pc+4, fetch_cnt+1.
- RUN, no redirect, !enq_ok: pc holds; im_addr is stable; nothing is dropped.
- redirect_valid (any state except under reset) has top priority:
  - Queue cleared: count<=0; a handshake in the same cycle counts as consumed and is then discarded.
  - No enqueue that cycle.
  - pc<=redirect_pc; state<=RUN.
- Misaligned target: state is RUN and pc[1:0]!=0.
  - When enq_ok, push {pc, 32'h0000_0013, 1}, fetch_cnt+1, state<=HALT; pc holds.
- Address wrap: im_addr uses only pc[IM_AW+1:2]; the full 32-bit pc increments, so 0x1FC is followed by 0x200, which maps to word 0.
- Latency:
  - First enqueue happens in the cycle after BOOT; out_valid rises 2 cycles after rst deasserts.
  - A redirect at edge t drops out_valid after t. The first new entry is pushed at t+1 and is visible after t+1.
- Throughput: 1 instruction/cycle while out_ready stays high.
- Outputs are driven from registered queue storage; there is no combinational path from im_dout to out_*.

Decomposition:
- Shared package holds:
  - NOP_INSTR = 32'h0000_0013
  - state encoding BOOT/RUN/HALT (2-bit)
  - XLEN = 32
  - queue entry struct {pc[31:0], instr[31:0], misalign}
- Sub-module if_fetch_q: parameterized synchronous FIFO of entries.
  - Ports: push, pop, flush, full, empty.
  - Registered head output.
  - Pointer wrap at QDEPTH.
  - Same-cycle push and pop are legal when full.

Test Plan:
- Reset release, ROM[0..2]=0x12345037/0x00A00113/0x01400193, out_ready=1 -> out_valid rises 2 cycles after reset; pairs (0x0, 0x12345037), (0x4, 0x00A00113), (0x8, 0x01400193) on consecutive cycles; fetch_cnt=3.
- out_ready=0 for 6 cycles after the first entry -> count saturates at 2, pc holds at 0x8, im_addr=2. On release, entries 0x0, 0x4, 0x8 arrive in order with no gaps or duplicates.
- Queue full, redirect_pc=0x40 with out_ready=1 in the same cycle -> queue flushed; the next out_pc is 0x40 carrying ROM[16]; no stale 0x8 appears.
- Redirect to 0x6 -> one entry (pc=0x6, instr=0x13, misalign=1), then out_valid=0 indefinitely. A redirect to 0x0 resumes fetch with ROM[0].
- Redirect to 0x1FC -> im_addr=127 and then 0; out_pc=0x1FC and then 0x200, with out_instr=ROM[127] and then ROM[0].
- Assert rst for 1 cycle while the queue is full and out_ready=0 -> out_valid=0, fetch_cnt=0, pc=RESET_PC; normal BOOT sequence follows.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Queue entry layout, FSM encoding and the filler instruction.
package if_fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misalign;
  } fq_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-to-decode handshake bundle.
// The fetch side is the master, decode is the slave.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_misalign;

  modport master (
    output out_valid,
    output out_pc,
    output out_instr,
    output out_misalign,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pc,
    input  out_instr,
    input  out_misalign,
    output out_ready
  );

endinterface

// File: rtl/if_fetch_q.sv
// Small synchronous FIFO of fetch entries with flush.
// Head is read straight from register storage.
module if_fetch_q
  import if_fetch_unit_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  fq_entry_t push_data,
  output fq_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  fq_entry_t mem_q [QDEPTH];
  fq_entry_t mem_d [QDEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CW'(QDEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_q];

  // next-state for storage, pointers and occupancy
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d = ptr_inc(wr_q);
      end
      if (pop) begin
        rd_d = ptr_inc(rd_q);
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // register update with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, reads the ROM and
// queues {pc, instr} for decode; takes redirects.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = 7,
  parameter int          QDEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_dout,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  if_fetch_unit_if.master  dec,
  output logic [31:0]      fetch_cnt
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        push, pop, flush;
  logic        full, empty;
  logic        deq, enq_ok;
  fq_entry_t   push_data, head;

  assign im_addr   = pc_q[IM_AW+1:2];
  assign fetch_cnt = fetch_cnt_q;

  assign dec.out_valid    = ~empty;
  assign dec.out_pc       = head.pc;
  assign dec.out_instr    = head.instr;
  assign dec.out_misalign = head.misalign;

  assign deq    = ~empty & dec.out_ready;
  assign enq_ok = ~full | deq;
  assign pop    = deq;

  // fetch FSM: redirect wins, misaligned PC parks in HALT
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    push        = 1'b0;
    flush       = 1'b0;
    push_data   = '{pc: pc_q, instr: im_dout, misalign: 1'b0};
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_pc;
      state_d = ST_RUN;
    end else begin
      unique case (1'b1)
        (state_q == ST_BOOT): state_d = ST_RUN;
        (state_q == ST_RUN): begin
          if (enq_ok) begin
            push        = 1'b1;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
            if (pc_q[1:0] != 2'b00) begin
              push_data.instr    = NOP_INSTR;
              push_data.misalign = 1'b1;
              state_d            = ST_HALT;
            end else begin
              pc_d = pc_q + 32'd4;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // state, PC and fetch counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  if_fetch_q #(
    .QDEPTH(QDEPTH)
  ) u_q (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .push_data(push_data),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a queue-level model
// predicts entries, a negedge monitor checks the handshake.
module tb_if_fetch_unit;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  im_addr;
  logic [31:0] im_dout;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] fetch_cnt;
  logic        rdy = 1'b1;

  logic [31:0] rom [128];

  if_fetch_unit_if dec ();

  assign im_dout       = rom[im_addr];
  assign dec.out_ready = rdy;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC(32'h0),
    .IM_AW   (7),
    .QDEPTH  (QD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .im_addr       (im_addr),
    .im_dout       (im_dout),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec           (dec.master),
    .fetch_cnt     (fetch_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t        exp_q [$];
  int          mode = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_cnt = 32'h0;
  bit          started = 1'b0;
  int          errors = 0;
  int          checks = 0;

  function automatic void chk(string name, logic [63:0] got,
                              logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h at %0t",
               name, got, want, $time);
    end
  endfunction

  // reference model: what each clock edge does to the
  // pending-instruction stream (mode 0=boot 1=run 2=halt)
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        m_pc    = 32'h0;
        m_cnt   = 32'h0;
        mode    = 0;
        started = 1'b1;
      end else if (started) begin
        if (redirect_valid) begin
          exp_q.delete();
          m_pc = redirect_pc;
          mode = 1;
        end else if (mode == 0) begin
          mode = 1;
        end else if (mode == 1 && exp_q.size() < QD) begin
          exp_t e;
          e.pc = m_pc;
          if (m_pc[1:0] != 2'b00) begin
            e.instr = 32'h0000_0013;
            e.mis   = 1'b1;
            mode    = 2;
          end else begin
            e.instr = rom[m_pc[8:2]];
            e.mis   = 1'b0;
            m_pc    = m_pc + 32'd4;
          end
          exp_q.push_back(e);
          m_cnt = m_cnt + 32'd1;
        end
      end
    end
  end

  // monitor: compare presented head against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("out_valid", 64'(dec.out_valid),
            64'(exp_q.size() != 0));
        chk("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
        chk("im_addr", 64'(im_addr), 64'(m_pc[8:2]));
        if (dec.out_valid && rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_entry: got pc=%0h want none",
                     dec.out_pc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_pc", 64'(dec.out_pc), 64'(e.pc));
            chk("out_instr", 64'(dec.out_instr), 64'(e.instr));
            chk("out_misalign", 64'(dec.out_misalign),
                64'(e.mis));
          end
        end
      end
    end
  end

  task automatic step(input bit r, input bit rv,
                      input logic [31:0] rp, input bit rd);
    @(posedge clk);
    #1;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    rdy            = rd;
  endtask

  task automatic idle(input int n, input bit rd);
    repeat (n) step(1'b0, 1'b0, 32'h0, rd);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    rom[0] = 32'h1234_5037;
    rom[1] = 32'h00A0_0113;
    rom[2] = 32'h0140_0193;

    step(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("rst_valid", 64'(dec.out_valid), 64'h0);
    chk("rst_pc", 64'(dec.out_pc), 64'h0);
    chk("rst_instr", 64'(dec.out_instr), 64'h0);
    chk("rst_mis", 64'(dec.out_misalign), 64'h0);
    chk("rst_cnt", 64'(fetch_cnt), 64'h0);
    chk("rst_addr", 64'(im_addr), 64'h0);

    // boot, first entry, then stall with decode blocked
    idle(2, 1'b1);
    idle(6, 1'b0);
    idle(3, 1'b1);

    // fill the queue, then redirect with a same-cycle handshake
    idle(4, 1'b0);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    idle(4, 1'b1);

    // misaligned target halts; aligned redirect resumes
    step(1'b0, 1'b1, 32'h6, 1'b1);
    idle(8, 1'b1);
    step(1'b0, 1'b1, 32'h0, 1'b1);
    idle(4, 1'b1);

    // ROM word address wrap
    step(1'b0, 1'b1, 32'h1FC, 1'b1);
    idle(5, 1'b1);

    // reset while full and stalled
    idle(4, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    idle(8, 1'b1);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      bit          r, rv, rd;
      logic [31:0] tgt;
      r  = ($urandom_range(0, 499) == 0);
      rv = ($urandom_range(0, 15) == 0);
      rd = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       tgt = 32'h1FC;
        1:       tgt = (32'($urandom_range(0, 127)) << 2) |
                       32'($urandom_range(1, 3));
        default: tgt = 32'($urandom_range(0, 255)) << 2;
      endcase
      step(r, rv, tgt, rd);
    end
    idle(4, 1'b1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
